fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit RISC pipeline and the producer of the IF/ID pipeline register that the decode stage consumes. It drives the instruction-memory address from the PC, assembles one- or two-word instructions (opcode word plus 16-bit immediate), and presents them to decode with a valid flag. It honours stall requests from the hazard unit, redirects on taken branches, and stops fetching after a HLT.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage: FSM states, instruction-format fields, bubble word.
// Pure definitions, no timing or flow control.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [1:0]  TWO_WORD_PREFIX = 2'b11;
    localparam int          TW_HI           = 15;
    localparam int          TW_LO           = 14;

    localparam logic [4:0]  OPC_HLT         = 5'b00001;
    localparam int          OPC_HI          = 15;
    localparam int          OPC_LO          = 11;

    localparam logic [15:0] NOP_INST        = 16'h0000;

    function automatic logic is_two_word(input logic [15:0] w);
        return w[TW_HI:TW_LO] == TWO_WORD_PREFIX;
    endfunction

    function automatic logic is_hlt(input logic [15:0] w);
        return w[OPC_HI:OPC_LO] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register, one edge of latency; clr beats ld beats bub, and with none
// asserted (stall) every field holds.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic                bub,
    input  logic                clr,
    input  logic [15:0]         d_inst,
    input  logic [15:0]         d_imm,
    input  logic [PC_WIDTH-1:0] d_pc,
    output logic [15:0]         inst,
    output logic [15:0]         imm,
    output logic [PC_WIDTH-1:0] pc,
    output logic                valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst  <= NOP_INST;
            imm   <= 16'h0000;
            pc    <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            // Redirect flush: the pc field is left as-is since a bubble's pc is never used.
            inst  <= NOP_INST;
            imm   <= 16'h0000;
            valid <= 1'b0;
        end else if (ld) begin
            inst  <= d_inst;
            imm   <= d_imm;
            pc    <= d_pc;
            valid <= 1'b1;
        end else if (bub) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-word instructions reach IF/ID one edge after their address, two-word
// ones two edges with a bubble; stall freezes all state, branch_taken overrides stall.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [15:0]         if_id_inst,
    output logic [15:0]         if_id_imm,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic                if_id_valid
);

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic [15:0]         hold, hold_n;
    logic [PC_WIDTH-1:0] hold_pc, hold_pc_n;
    logic                ld, bub, clr;
    logic [15:0]         d_inst, d_imm;
    logic [PC_WIDTH-1:0] d_pc;

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            hold    <= NOP_INST;
            hold_pc <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            hold    <= hold_n;
            hold_pc <= hold_pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        hold_n    = hold;
        hold_pc_n = hold_pc;
        ld        = 1'b0;
        bub       = 1'b0;
        clr       = 1'b0;
        d_inst    = imem_rdata;
        d_imm     = 16'h0000;
        d_pc      = pc;
        if (branch_taken) begin
            pc_n    = branch_target;
            state_n = S_FETCH;
            hold_n  = NOP_INST;
            clr     = 1'b1;
        end else if (!stall) begin
            case (state)
                S_FETCH: begin
                    pc_n = pc + PC_WIDTH'(1);
                    if (is_two_word(imem_rdata)) begin
                        hold_n    = imem_rdata;
                        hold_pc_n = pc;
                        bub       = 1'b1;
                        state_n   = S_IMM;
                    end else begin
                        ld = 1'b1;
                        if (is_hlt(imem_rdata)) begin
                            state_n = S_HALT;
                        end
                    end
                end
                // The word read here is an immediate and is never inspected as an opcode.
                S_IMM: begin
                    ld      = 1'b1;
                    d_inst  = hold;
                    d_imm   = imem_rdata;
                    d_pc    = hold_pc;
                    pc_n    = pc + PC_WIDTH'(1);
                    state_n = S_FETCH;
                end
                S_HALT: begin
                    bub = 1'b1;
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    if_id_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .bub    (bub),
        .clr    (clr),
        .d_inst (d_inst),
        .d_imm  (d_imm),
        .d_pc   (d_pc),
        .inst   (if_id_inst),
        .imm    (if_id_imm),
        .pc     (if_id_pc),
        .valid  (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-accurate vector table on a RESET_PC=0 instance, plus an
// ISA-level scoreboard on a RESET_PC=FFFF instance that exercises the address wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] tgt = 16'h0000;
    logic        stall2 = 1'b0;
    logic        br2 = 1'b0;
    logic [15:0] tgt2 = 16'h0000;

    logic [15:0] mem  [65536];
    logic [15:0] mem2 [65536];

    logic [15:0] addr, rdata, inst, imm, pc;
    logic        valid;
    logic [15:0] addr2, rdata2, inst2, imm2, pc2;
    logic        valid2;

    assign rdata  = mem[addr];
    assign rdata2 = mem2[addr2];

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_addr(addr), .imem_rdata(rdata),
        .stall(stall), .branch_taken(br), .branch_target(tgt),
        .if_id_inst(inst), .if_id_imm(imm), .if_id_pc(pc), .if_id_valid(valid)
    );

    fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst2), .imem_addr(addr2), .imem_rdata(rdata2),
        .stall(stall2), .branch_taken(br2), .branch_target(tgt2),
        .if_id_inst(inst2), .if_id_imm(imm2), .if_id_pc(pc2), .if_id_valid(valid2)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        valid;
        logic        chk_ii;
        logic        chk_pc;
        logic [15:0] inst;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [15:0] addr;
    } vec_t;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] imm;
        logic [15:0] pc;
    } ent_t;

    vec_t vecs[$];
    ent_t sbq[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(logic s, logic b, logic [15:0] t, logic v, logic ii, logic p,
                                logic [15:0] ei, logic [15:0] em, logic [15:0] ep, logic [15:0] ea);
        vec_t r;
        r.stall = s;  r.br = b;  r.tgt = t;  r.valid = v;
        r.chk_ii = ii;  r.chk_pc = p;
        r.inst = ei;  r.imm = em;  r.pc = ep;  r.addr = ea;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Walks the program as an ISA reader would, stopping at the first HLT.
    task automatic build_expected(input logic [15:0] start);
        logic [15:0] a, nxt, op;
        ent_t        e;
        a = start;
        for (int k = 0; k < 16; k++) begin
            op  = mem2[a];
            nxt = a + 16'd1;
            if (op[15:14] == 2'b11) begin
                e = '{inst: op, imm: mem2[nxt], pc: a};
                sbq.push_back(e);
                a = nxt + 16'd1;
            end else begin
                e = '{inst: op, imm: 16'h0000, pc: a};
                sbq.push_back(e);
                if (op[15:11] == 5'b00001) break;
                a = nxt;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ent_t e;
        for (int a = 0; a < 65536; a++) begin
            mem[a]  = 16'h1000 | (16'(a) & 16'h0FFF);
            mem2[a] = 16'h1000 | (16'(a) & 16'h0FFF);
        end
        mem[16'h0000] = 16'h1234;  mem[16'h0001] = 16'hC005;  mem[16'h0002] = 16'hBEEF;
        mem[16'h0003] = 16'hC00A;  mem[16'h0004] = 16'h0800;  mem[16'h0005] = 16'h0800;
        mem[16'h0011] = 16'hC0AA;  mem[16'hFFFF] = 16'hC0FF;
        mem2[16'h0000] = 16'h1234; mem2[16'h0001] = 16'hC005; mem2[16'h0002] = 16'hBEEF;
        mem2[16'h0003] = 16'hC00A; mem2[16'h0004] = 16'h0800; mem2[16'h0005] = 16'h0800;

        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'h1234,16'h0000,16'h0000, 16'h0001));
        vecs.push_back(mk(0,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0002));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'hC005,16'hBEEF,16'h0001, 16'h0003));
        vecs.push_back(mk(0,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0004));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0004));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'hC00A,16'h0800,16'h0003, 16'h0005));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'h0800,16'h0000,16'h0005, 16'h0006));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0006));
        vecs.push_back(mk(1,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0006));
        vecs.push_back(mk(0,1,16'h0010, 0,1,0, 16'h0000,16'h0000,16'h0000, 16'h0010));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'h1010,16'h0000,16'h0010, 16'h0011));
        vecs.push_back(mk(0,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0012));
        vecs.push_back(mk(1,1,16'h0040, 0,1,0, 16'h0000,16'h0000,16'h0000, 16'h0040));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'h1040,16'h0000,16'h0040, 16'h0041));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'h1041,16'h0000,16'h0041, 16'h0042));
        vecs.push_back(mk(1,0,16'h0000, 1,1,1, 16'h1041,16'h0000,16'h0041, 16'h0042));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'h1042,16'h0000,16'h0042, 16'h0043));
        vecs.push_back(mk(0,1,16'hFFFF, 0,1,0, 16'h0000,16'h0000,16'h0000, 16'hFFFF));
        vecs.push_back(mk(0,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0000));
        vecs.push_back(mk(0,0,16'h0000, 1,1,1, 16'hC0FF,16'h1234,16'hFFFF, 16'h0001));
        vecs.push_back(mk(0,0,16'h0000, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0002));

        #2 rst = 1'b0; rst2 = 1'b0;
        #1;
        chk("reset valid", {15'b0, valid}, 16'h0000);
        chk("reset inst",  inst, 16'h0000);
        chk("reset imm",   imm,  16'h0000);
        chk("reset pc",    pc,   16'h0000);
        chk("reset addr",  addr, 16'h0000);
        chk("reset addr2", addr2, 16'hFFFF);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall;
            br    = vecs[i].br;
            tgt   = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("row%0d valid", i), {15'b0, valid}, {15'b0, vecs[i].valid});
            chk($sformatf("row%0d addr", i), addr, vecs[i].addr);
            if (vecs[i].chk_ii) begin
                chk($sformatf("row%0d inst", i), inst, vecs[i].inst);
                chk($sformatf("row%0d imm", i), imm, vecs[i].imm);
            end
            if (vecs[i].chk_pc) chk($sformatf("row%0d pc", i), pc, vecs[i].pc);
        end
        stall = 1'b0;
        br    = 1'b0;

        // Reset asserted while in S_IMM must act between edges.
        #2 rst = 1'b0;
        #1;
        chk("midrst valid", {15'b0, valid}, 16'h0000);
        chk("midrst inst",  inst, 16'h0000);
        chk("midrst imm",   imm,  16'h0000);
        chk("midrst pc",    pc,   16'h0000);
        chk("midrst addr",  addr, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst valid", {15'b0, valid}, 16'h0001);
        chk("post-rst inst",  inst, 16'h1234);
        chk("post-rst pc",    pc,   16'h0000);
        chk("post-rst addr",  addr, 16'h0001);

        build_expected(16'hFFFF);
        rst2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk("wrap addr2", addr2, 16'h0000);
            if (valid2) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL sb extra: got inst %h pc %h expected no more instructions", inst2, pc2);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("sb inst @%h", e.pc), inst2, e.inst);
                    chk($sformatf("sb imm @%h", e.pc),  imm2,  e.imm);
                    chk($sformatf("sb pc @%h", e.pc),   pc2,   e.pc);
                end
            end
        end
        chk("sb drained", 16'(sbq.size()), 16'h0000);
        chk("halt addr2", addr2, 16'h0006);

        // Reset while halted.
        #2 rst2 = 1'b0;
        #1;
        chk("haltrst addr2",  addr2, 16'hFFFF);
        chk("haltrst valid2", {15'b0, valid2}, 16'h0000);
        chk("haltrst inst2",  inst2, 16'h0000);
        chk("haltrst imm2",   imm2,  16'h0000);
        chk("haltrst pc2",    pc2,   16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
